shift_issue_ctrl: RTL and testbench

//  Issue/retire stage wrapped around the ShiftLR barrel shifter in the functional unit.

---
 rtl/shift_issue_ctrl_if.sv | 28 ++
 rtl/shift_issue_ctrl.sv | 150 +++++++++++++++
 tb/tb_shift_issue_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_issue_ctrl_if.sv
// Request/result handshake bundle for the shift issue stage.
// The master drives ops in and takes results out; the slave is the issue controller.
interface shift_issue_ctrl_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [SHW-1:0]   in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/shift_issue_ctrl.sv
// Issue/retire stage around a fixed-latency barrel shifter: registers operands,
// tracks tags alongside the shifter pipe and retires results into an in-order FIFO.
module shift_issue_ctrl #(
  parameter int WIDTH     = 32,
  parameter int SHW       = 5,
  parameter int TAG_W     = 4,
  parameter int RES_DEPTH = 4,
  parameter int SH_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst,
  shift_issue_ctrl_if.slave bus,
  output logic [WIDTH-1:0]  sh_x,
  output logic [SHW-1:0]    sh_s,
  output logic              sh_left,
  output logic              sh_log,
  input  logic [WIDTH-1:0]  sh_z,
  output logic              busy
);

  localparam int PTR_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int CNT_W = $clog2(RES_DEPTH + 1);
  localparam int OCC_W = $clog2(RES_DEPTH + SH_LAT + 2);

  logic             accept;
  logic             iss_vld_reg;
  logic [TAG_W-1:0] iss_tag_reg;
  logic [WIDTH-1:0] sh_x_reg;
  logic [SHW-1:0]   sh_s_reg;
  logic             sh_left_reg;
  logic             sh_log_reg;

  logic [SH_LAT-1:0] pipe_vld_reg;
  logic [TAG_W-1:0]  pipe_tag_reg [SH_LAT];
  logic [SH_LAT-1:0] pipe_src_vld;
  logic [TAG_W-1:0]  pipe_src_tag [SH_LAT];

  logic [WIDTH-1:0] data_mem [RES_DEPTH];
  logic [TAG_W-1:0] tag_mem  [RES_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             push, pop, fifo_nonempty;
  logic [TAG_W-1:0] push_tag;
  logic [OCC_W-1:0] occupancy;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RES_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign accept = bus.in_valid && bus.in_ready;

  // Operand register: holds its payload between ops, only the valid bit drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss_vld_reg <= 1'b0;
      iss_tag_reg <= '0;
      sh_x_reg    <= '0;
      sh_s_reg    <= '0;
      sh_left_reg <= 1'b0;
      sh_log_reg  <= 1'b0;
    end else begin
      iss_vld_reg <= accept;
      if (accept) begin
        iss_tag_reg <= bus.in_tag;
        sh_x_reg    <= bus.in_a;
        sh_s_reg    <= bus.in_b;
        sh_left_reg <= bus.in_op[1];
        sh_log_reg  <= bus.in_op[1] ^ bus.in_op[0];
      end
    end
  end

  assign sh_x    = sh_x_reg;
  assign sh_s    = sh_s_reg;
  assign sh_left = sh_left_reg;
  assign sh_log  = sh_log_reg;

  // Tag pipe mirrors the shifter latency so its last stage lines up with sh_z.
  generate
    for (genvar gi = 0; gi < SH_LAT; gi++) begin : g_pipe_src
      if (gi == 0) begin : g_first
        assign pipe_src_vld[gi] = iss_vld_reg;
        assign pipe_src_tag[gi] = iss_tag_reg;
      end else begin : g_rest
        assign pipe_src_vld[gi] = pipe_vld_reg[gi-1];
        assign pipe_src_tag[gi] = pipe_tag_reg[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld_reg <= '0;
      for (int i = 0; i < SH_LAT; i++) pipe_tag_reg[i] <= '0;
    end else begin
      pipe_vld_reg <= pipe_src_vld;
      for (int i = 0; i < SH_LAT; i++) pipe_tag_reg[i] <= pipe_src_tag[i];
    end
  end

  assign push          = pipe_vld_reg[SH_LAT-1];
  assign push_tag      = pipe_tag_reg[SH_LAT-1];
  assign fifo_nonempty = (count_reg != '0);
  assign pop           = fifo_nonempty && bus.out_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_reg] <= sh_z;
      tag_mem[wr_ptr_reg]  <= push_tag;
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      count_reg <= count_next;
    end
  end

  // Every op past the input port owns a FIFO slot, so the shifter never needs to stall.
  always_comb begin
    occupancy = OCC_W'(count_reg) + OCC_W'(iss_vld_reg);
    for (int i = 0; i < SH_LAT; i++) occupancy = occupancy + OCC_W'(pipe_vld_reg[i]);
  end

  assign bus.in_ready  = (occupancy < OCC_W'(RES_DEPTH));
  assign bus.out_valid = fifo_nonempty;
  assign bus.out_data  = fifo_nonempty ? data_mem[rd_ptr_reg] : '0;
  assign bus.out_tag   = fifo_nonempty ? tag_mem[rd_ptr_reg]  : '0;
  assign busy          = iss_vld_reg | (|pipe_vld_reg) | fifo_nonempty;

  always @(posedge clk) begin
    if (!rst && push) assert (count_reg != CNT_W'(RES_DEPTH));
  end

endmodule

// File: tb/tb_shift_issue_ctrl.sv
// Randomized and directed bench for shift_issue_ctrl with a queue-based result model
// and a behavioural one-cycle shifter standing in for the real ShiftLR.
module tb_shift_issue_ctrl;
  localparam int WIDTH = 32, SHW = 5, TAG_W = 4, RES_DEPTH = 4, SH_LAT = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [WIDTH-1:0] sh_x, sh_z;
  logic [SHW-1:0]   sh_s;
  logic             sh_left, sh_log, busy;

  shift_issue_ctrl_if #(.WIDTH(WIDTH), .SHW(SHW), .TAG_W(TAG_W)) bus ();

  shift_issue_ctrl #(.WIDTH(WIDTH), .SHW(SHW), .TAG_W(TAG_W), .RES_DEPTH(RES_DEPTH), .SH_LAT(SH_LAT)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .sh_x(sh_x), .sh_s(sh_s), .sh_left(sh_left), .sh_log(sh_log),
    .sh_z(sh_z), .busy(busy)
  );

  // Stand-in shifter: one register stage from X/S/LEFT/LOG to Z.
  always @(posedge clk) begin
    if (sh_left)     sh_z <= sh_x << sh_s;
    else if (sh_log) sh_z <= sh_x >> sh_s;
    else             sh_z <= WIDTH'($signed(sh_x) >>> sh_s);
  end

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [TAG_W-1:0] tag;
    int               rdy;
  } ent_t;

  ent_t             q[$];
  logic [TAG_W-1:0] pop_log[$];
  int               pop_edge_log[$];
  int               n_checks = 0, n_pass = 0;
  int               edge_cnt = 0, acc_cnt = 0;
  logic             last_acc = 1'b0;
  logic [1:0]       last_op;
  logic [WIDTH-1:0] last_a;
  logic [SHW-1:0]   last_b;

  function automatic logic [WIDTH-1:0] ref_op(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                              input logic [SHW-1:0] b);
    logic signed [WIDTH-1:0] sa;
    sa = a;
    case (op)
      2'b00:   return WIDTH'(sa >>> b);
      2'b01:   return a >> b;
      default: return a << b;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_cnt);
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [WIDTH-1:0] a,
                       input logic [SHW-1:0] b, input logic [TAG_W-1:0] tg);
    bus.in_valid = v;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_tag   = tg;
  endtask

  task automatic compare();
    logic ev;
    ev = (q.size() > 0) && (edge_cnt >= q[0].rdy);
    chk("in_ready",  64'(bus.in_ready),  64'(q.size() < RES_DEPTH));
    chk("out_valid", 64'(bus.out_valid), 64'(ev));
    chk("busy",      64'(busy),          64'(q.size() > 0));
    if (ev) begin
      chk("out_data", 64'(bus.out_data), 64'(q[0].data));
      chk("out_tag",  64'(bus.out_tag),  64'(q[0].tag));
    end
    if (last_acc) begin
      chk("sh_x",    64'(sh_x),    64'(last_a));
      chk("sh_s",    64'(sh_s),    64'(last_b));
      chk("sh_left", 64'(sh_left), 64'(last_op == 2'b10 || last_op == 2'b11));
      chk("sh_log",  64'(sh_log),  64'(last_op == 2'b01 || last_op == 2'b10));
    end
  endtask

  // One clock: sample handshakes before the edge, advance the model, check at the falling edge.
  task automatic step();
    logic             acc, pop;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [SHW-1:0]   b;
    logic [TAG_W-1:0] tg, ptag;
    acc  = bus.in_valid && bus.in_ready;
    pop  = bus.out_valid && bus.out_ready;
    op   = bus.in_op;
    a    = bus.in_a;
    b    = bus.in_b;
    tg   = bus.in_tag;
    ptag = bus.out_tag;
    @(posedge clk);
    edge_cnt++;
    if (pop) begin
      pop_log.push_back(ptag);
      pop_edge_log.push_back(edge_cnt);
      if (q.size() > 0) void'(q.pop_front());
    end
    if (acc) begin
      q.push_back('{data: ref_op(op, a, b), tag: tg, rdy: edge_cnt + SH_LAT + 1});
      acc_cnt++;
    end
    last_acc = acc;
    last_op  = op;
    last_a   = a;
    last_b   = b;
    @(negedge clk);
    compare();
  endtask

  task automatic reset_mid(input string name);
    #2 rst = 1'b1;
    #1;
    chk({name, "_in_ready"},  64'(bus.in_ready),  64'd1);
    chk({name, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    chk({name, "_busy"},      64'(busy),          64'd0);
    chk({name, "_sh_x"},      64'(sh_x),          64'd0);
    chk({name, "_sh_s"},      64'(sh_s),          64'd0);
    chk({name, "_sh_left"},   64'(sh_left),       64'd0);
    chk({name, "_sh_log"},    64'(sh_log),        64'd0);
    chk({name, "_out_data"},  64'(bus.out_data),  64'd0);
    chk({name, "_out_tag"},   64'(bus.out_tag),   64'd0);
    drive(1'b0, 2'b00, '0, '0, '0);
    q.delete();
    last_acc = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 compare();
  endtask

  task automatic run_single(input string name, input logic [1:0] op, input logic [WIDTH-1:0] a,
                            input logic [SHW-1:0] b, input logic [TAG_W-1:0] tg,
                            input logic [WIDTH-1:0] exp);
    bus.out_ready = 1'b1;
    drive(1'b1, op, a, b, tg);
    step();
    chk({name, "_accept"}, 64'(last_acc), 64'd1);
    drive(1'b0, 2'b00, '0, '0, '0);
    step();
    chk({name, "_early"}, 64'(bus.out_valid), 64'd0);
    step();
    chk({name, "_valid"}, 64'(bus.out_valid), 64'd1);
    chk({name, "_data"},  64'(bus.out_data),  64'(exp));
    chk({name, "_tag"},   64'(bus.out_tag),   64'(tg));
    step();
  endtask

  initial begin
    int tag_i, n, bubbles, acc_before;
    drive(1'b0, 2'b00, '0, '0, '0);
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 compare();

    // Reset mid-cycle with an op sitting in the issue register.
    drive(1'b1, 2'b00, 32'h0000_1234, 5'd1, 4'd1);
    step();
    reset_mid("rst1");

    run_single("sra", 2'b00, 32'h8000_0000, 5'd4, 4'd3, 32'hF800_0000);
    run_single("srl", 2'b01, 32'h8000_0000, 5'd31, 4'd6, 32'h0000_0001);
    run_single("sll", 2'b10, 32'h0000_0001, 5'd31, 4'd7, 32'h8000_0000);
    run_single("sla", 2'b11, 32'h0000_000F, 5'd4, 4'd8, 32'h0000_00F0);
    run_single("b0_sra", 2'b00, 32'h8000_1234, 5'd0, 4'd9,  32'h8000_1234);
    run_single("b0_srl", 2'b01, 32'hA5A5_0F0F, 5'd0, 4'd10, 32'hA5A5_0F0F);
    run_single("b0_sll", 2'b10, 32'hDEAD_BEEF, 5'd0, 4'd11, 32'hDEAD_BEEF);
    run_single("b0_sla", 2'b11, 32'h0123_4567, 5'd0, 4'd12, 32'h0123_4567);

    // Backpressure: credits cap acceptance at RES_DEPTH.
    pop_log.delete();
    bus.out_ready = 1'b0;
    tag_i = 0;
    acc_before = acc_cnt;
    for (int c = 1; c <= 6; c++) begin
      if (c >= 5) chk("bp_ready_low", 64'(bus.in_ready), 64'd0);
      drive(1'b1, 2'(tag_i % 4), 32'h100 + 32'(tag_i), 5'(tag_i), 4'(tag_i));
      step();
      if (last_acc) tag_i++;
    end
    chk("bp_accepted", 64'(acc_cnt - acc_before), 64'd4);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 40 && pop_log.size() < 6; c++) begin
      if (tag_i < 6) drive(1'b1, 2'(tag_i % 4), 32'h100 + 32'(tag_i), 5'(tag_i), 4'(tag_i));
      else           drive(1'b0, 2'b00, '0, '0, '0);
      step();
      if (last_acc) tag_i++;
    end
    drive(1'b0, 2'b00, '0, '0, '0);
    chk("bp_pops", 64'(pop_log.size()), 64'd6);
    for (int i = 0; i < pop_log.size(); i++) chk("bp_order", 64'(pop_log[i]), 64'(i));

    // Full-rate streaming of random ops.
    pop_edge_log.delete();
    n = 0;
    bubbles = 0;
    for (int c = 0; c < 100 && n < 32; c++) begin
      drive(1'b1, 2'($urandom_range(0, 3)), $urandom,
            ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom), 4'($urandom));
      step();
      if (last_acc) n++;
      else bubbles++;
    end
    drive(1'b0, 2'b00, '0, '0, '0);
    for (int c = 0; c < 20 && q.size() > 0; c++) step();
    chk("stream_accepted", 64'(n), 64'd32);
    chk("stream_bubbles", 64'(bubbles), 64'd0);
    chk("stream_pops", 64'(pop_edge_log.size()), 64'd32);
    if (pop_edge_log.size() >= 32)
      chk("stream_span", 64'(pop_edge_log[31] - pop_edge_log[0]), 64'd31);

    // Reset with the FIFO and pipe partly occupied.
    bus.out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 2'(c), 32'hF0F0_0000 + 32'(c), 5'(c + 1), 4'(c));
      step();
    end
    chk("mf_busy_before", 64'(busy), 64'd1);
    reset_mid("rst6");
    chk("mf_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mf_busy", 64'(busy), 64'd0);
    chk("mf_in_ready", 64'(bus.in_ready), 64'd1);
    run_single("mf_next", 2'b00, 32'hF000_0000, 5'd8, 4'd5, 32'hFFF0_0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
